// File: rtl/trail_sched.sv
// trail_sched: per-frame sequencer for the 112x112 trail memory.
//
// Once per qualified frame tick it reads the cells under both light-cycle
// heads, updates the sticky collision flags, then writes the heads back as
// new trail. A game start sweeps the whole memory to zero.
//
// Optional feature macro: TRAIL_HEADON_EN (head-on detection on equal
// in-bounds head addresses).
//
// Ports:
//   Clk, Reset                 50 MHz clock, synchronous active-high reset
//   frame_clk                  asynchronous frame strobe (~60 Hz)
//   Game_State[2:0]            1 = START, 2 = PLAY, others idle
//   Blue_X/Y, Red_X/Y[6:0]     head cell coordinates (valid 0..111)
//   Blue_dir, Red_dir[1:0]     reserved, unused
//   mem_we/mem_waddr/mem_wdata trail RAM write port
//   mem_raddr/mem_rdata        trail RAM read port (registered, latency 1)
//   collision_blue/red         sticky collision flags
//   busy                       high in every non-IDLE state
//   frame_done                 one-cycle pulse at end of a frame sequence
//   frame_missed               one-cycle pulse when a frame tick is dropped
module trail_sched (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [2:0]  Game_State,
    input  logic [6:0]  Blue_X,
    input  logic [6:0]  Blue_Y,
    input  logic [6:0]  Red_X,
    input  logic [6:0]  Red_Y,
    input  logic [1:0]  Blue_dir,
    input  logic [1:0]  Red_dir,
    output logic        mem_we,
    output logic [13:0] mem_waddr,
    output logic [2:0]  mem_wdata,
    output logic [13:0] mem_raddr,
    input  logic [2:0]  mem_rdata,
    output logic        collision_blue,
    output logic        collision_red,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_missed
);

    localparam int unsigned W     = 112;
    localparam int unsigned DEPTH = 12544;
    localparam int unsigned AW    = 14;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_RD_B, S_RD_R, S_CHK, S_WR_B, S_WR_R, S_DONE
    } state_t;

    state_t          r_state;
    logic            r_fs1, r_fs2, r_fs3;
    logic            r_start_q;
    logic            r_start_pend;
    logic [AW-1:0]   r_b_addr, r_r_addr;
    logic            r_b_oob, r_r_oob;
    logic            r_hit_b;
    logic            r_wr_r_en;

    logic            w_tick, w_qtick;
    logic            w_start_edge, w_start;
    logic            w_b_oob_in, w_r_oob_in;
    logic [AW-1:0]   w_b_addr_in, w_r_addr_in;
    logic            w_r_hit, w_headon;
    logic            w_cb_next, w_cr_next;
    logic            w_in_frame;
    logic            w_unused_dir;

    function automatic logic [AW-1:0] cell_addr(input logic [6:0] x, input logic [6:0] y);
        return AW'(y) * AW'(W) + AW'(x);
    endfunction

    // Direction inputs are reserved for future use.
    assign w_unused_dir = ^{Blue_dir, Red_dir};

    // Frame tick: rising edge of the synchronized strobe.
    assign w_tick  = r_fs2 & ~r_fs3;
    assign w_qtick = w_tick & (Game_State == 3'd2);

    // Start request: new START edge or one deferred from a frame sequence.
    assign w_start_edge = (Game_State == 3'd1) & ~r_start_q;
    assign w_start      = w_start_edge | r_start_pend;

    assign w_b_oob_in  = (Blue_X > 7'd111) | (Blue_Y > 7'd111);
    assign w_r_oob_in  = (Red_X  > 7'd111) | (Red_Y  > 7'd111);
    assign w_b_addr_in = cell_addr(Blue_X, Blue_Y);
    assign w_r_addr_in = cell_addr(Red_X, Red_Y);

    // Red read data arrives during CHK; out-of-bounds data is ignored.
    assign w_r_hit = ~r_r_oob & (mem_rdata != 3'd0);

`ifdef TRAIL_HEADON_EN
    assign w_headon = ~r_b_oob & ~r_r_oob & (r_b_addr == r_r_addr);
`else
    assign w_headon = 1'b0;
`endif

    // Flags are sticky: a set flag simply holds.
    assign w_cb_next = collision_blue | r_hit_b | r_b_oob | w_headon;
    assign w_cr_next = collision_red  | w_r_hit | r_r_oob | w_headon;

    assign w_in_frame = (r_state != S_IDLE) && (r_state != S_CLEAR);

    // Sequencer with registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state        <= S_IDLE;
            r_fs1          <= 1'b0;
            r_fs2          <= 1'b0;
            r_fs3          <= 1'b0;
            r_start_q      <= 1'b0;
            r_start_pend   <= 1'b0;
            r_b_addr       <= '0;
            r_r_addr       <= '0;
            r_b_oob        <= 1'b0;
            r_r_oob        <= 1'b0;
            r_hit_b        <= 1'b0;
            r_wr_r_en      <= 1'b0;
            mem_we         <= 1'b0;
            mem_waddr      <= '0;
            mem_wdata      <= '0;
            mem_raddr      <= '0;
            collision_blue <= 1'b0;
            collision_red  <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            frame_missed   <= 1'b0;
        end else begin
            r_fs1        <= frame_clk;
            r_fs2        <= r_fs1;
            r_fs3        <= r_fs2;
            r_start_q    <= (Game_State == 3'd1);
            frame_done   <= 1'b0;
            frame_missed <= 1'b0;

            // Any tick arriving while busy is lost.
            if ((r_state != S_IDLE) && w_tick) begin
                frame_missed <= 1'b0 | 1'b1;
            end
            if (w_in_frame && w_start_edge) begin
                r_start_pend <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state        <= S_CLEAR;
                        r_start_pend   <= 1'b0;
                        busy           <= 1'b1;
                        mem_we         <= 1'b1;
                        mem_waddr      <= '0;
                        mem_wdata      <= 3'd0;
                        collision_blue <= 1'b0;
                        collision_red  <= 1'b0;
                        if (w_qtick) begin
                            frame_missed <= 1'b1;
                        end
                    end else if (w_qtick) begin
                        r_state   <= S_RD_B;
                        busy      <= 1'b1;
                        r_b_addr  <= w_b_addr_in;
                        r_r_addr  <= w_r_addr_in;
                        r_b_oob   <= w_b_oob_in;
                        r_r_oob   <= w_r_oob_in;
                        mem_raddr <= w_b_oob_in ? '0 : w_b_addr_in;
                    end
                end
                S_CLEAR: begin
                    if (mem_waddr == AW'(DEPTH - 1)) begin
                        r_state   <= S_IDLE;
                        busy      <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_waddr <= '0;
                    end else begin
                        mem_waddr <= mem_waddr + AW'(1);
                    end
                end
                S_RD_B: begin
                    r_state   <= S_RD_R;
                    mem_raddr <= r_r_oob ? '0 : r_r_addr;
                end
                S_RD_R: begin
                    // Blue read data is valid this cycle.
                    r_state <= S_CHK;
                    r_hit_b <= ~r_b_oob & (mem_rdata != 3'd0);
                end
                S_CHK: begin
                    r_state        <= S_WR_B;
                    collision_blue <= w_cb_next;
                    collision_red  <= w_cr_next;
                    mem_we         <= ~r_b_oob & ~w_cb_next;
                    mem_waddr      <= r_b_addr;
                    mem_wdata      <= 3'd1;
                    r_wr_r_en      <= ~r_r_oob & ~w_cr_next;
                end
                S_WR_B: begin
                    r_state   <= S_WR_R;
                    mem_we    <= r_wr_r_en;
                    mem_waddr <= r_r_addr;
                    mem_wdata <= 3'd2;
                end
                S_WR_R: begin
                    r_state    <= S_DONE;
                    mem_we     <= 1'b0;
                    mem_waddr  <= '0;
                    mem_wdata  <= 3'd0;
                    frame_done <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trail_sched.sv
// Self-checking bench for trail_sched with a behavioural trail RAM
// (one write port, registered read of latency 1).
module tb_trail_sched;

    localparam int DEPTH = 12544;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [2:0]  Game_State;
    logic [6:0]  Blue_X, Blue_Y, Red_X, Red_Y;
    logic [1:0]  Blue_dir, Red_dir;
    logic        mem_we;
    logic [13:0] mem_waddr;
    logic [2:0]  mem_wdata;
    logic [13:0] mem_raddr;
    logic [2:0]  mem_rdata;
    logic        collision_blue, collision_red, busy, frame_done, frame_missed;

    int checks = 0;
    int errors = 0;

    // RAM model plus bench-side preload ports
    logic [2:0]  ram [0:DEPTH-1];
    logic        fill_req, poke_req;
    logic [2:0]  fill_val, poke_val;
    logic [13:0] poke_addr;

    // Per-cycle record of a frame sequence, index 1 = RD_B cycle
    logic        s_we   [1:7];
    logic [13:0] s_waddr[1:7];
    logic [2:0]  s_wdata[1:7];
    logic [13:0] s_raddr[1:7];
    logic        s_done [1:7];
    logic        s_cb   [1:7];
    logic        s_cr   [1:7];
    logic        s_busy [1:7];
    logic        s_miss [1:7];

    always #5 Clk = ~Clk;

    trail_sched dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Game_State(Game_State),
        .Blue_X(Blue_X), .Blue_Y(Blue_Y), .Red_X(Red_X), .Red_Y(Red_Y),
        .Blue_dir(Blue_dir), .Red_dir(Red_dir),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .collision_blue(collision_blue), .collision_red(collision_red),
        .busy(busy), .frame_done(frame_done), .frame_missed(frame_missed)
    );

    always @(posedge Clk) begin
        if (fill_req) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= fill_val;
        end else if (poke_req) begin
            ram[poke_addr] <= poke_val;
        end else if (mem_we) begin
            ram[mem_waddr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_raddr];
    end

    task automatic run_frame(input logic [6:0] bx, input logic [6:0] by,
                             input logic [6:0] rx, input logic [6:0] ry);
        logic found;
        Blue_X = bx; Blue_Y = by; Red_X = rx; Red_Y = ry;
        @(negedge Clk);
        frame_clk = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge Clk);
            if (busy === 1'b1) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) begin errors++; $display("FAIL frame_start busy=%b required 1", busy); end
        for (int t = 1; t <= 7; t++) begin
            if (t > 1) @(negedge Clk);
            s_we[t] = mem_we; s_waddr[t] = mem_waddr; s_wdata[t] = mem_wdata;
            s_raddr[t] = mem_raddr; s_done[t] = frame_done; s_cb[t] = collision_blue;
            s_cr[t] = collision_red; s_busy[t] = busy; s_miss[t] = frame_missed;
        end
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b required 0", mem_we); end
        checks++; if (mem_waddr !== 14'd0 || mem_raddr !== 14'd0 || mem_wdata !== 3'd0) begin
            errors++; $display("FAIL reset_addr waddr=%0d raddr=%0d wdata=%0d required 0", mem_waddr, mem_raddr, mem_wdata); end
        checks++; if ({busy, frame_done, frame_missed, collision_blue, collision_red} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got=%b required 00000", {busy, frame_done, frame_missed, collision_blue, collision_red}); end
    endtask

    task automatic test_clear(input logic inject_tick);
        int n, bad, nz, miss;
        logic found;
        fill_val = 3'd5; fill_req = 1'b1;
        @(negedge Clk);
        fill_req = 1'b0;
        Game_State = 3'd1;
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            @(negedge Clk);
            if (busy === 1'b1) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL clear_start busy=%b required 1", busy); end
        n = 0; bad = 0; miss = 0;
        while (busy === 1'b1 && n < 13000) begin
            if (mem_we !== 1'b1 || mem_waddr !== 14'(n) || mem_wdata !== 3'd0) bad++;
            if (frame_missed === 1'b1) miss++;
            n++;
            if (inject_tick && n == 100) frame_clk = 1'b1;
            if (inject_tick && n == 200) frame_clk = 1'b0;
            @(negedge Clk);
        end
        checks++; if (n != DEPTH) begin errors++; $display("FAIL clear_len busy_cycles=%0d required %0d", n, DEPTH); end
        checks++; if (bad != 0) begin errors++; $display("FAIL clear_writes bad_cycles=%0d required 0", bad); end
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== 3'd0) nz++;
        checks++; if (nz != 0) begin errors++; $display("FAIL clear_ram nonzero_cells=%0d required 0", nz); end
        checks++; if (collision_blue !== 1'b0 || collision_red !== 1'b0) begin
            errors++; $display("FAIL clear_flags got=%b%b required 00", collision_blue, collision_red); end
        checks++; if (miss != (inject_tick ? 1 : 0)) begin
            errors++; $display("FAIL clear_missed pulses=%0d required %0d", miss, inject_tick ? 1 : 0); end
        Game_State = 3'd2;
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_clean_frame;
        int miss;
        run_frame(7'd10, 7'd20, 7'd50, 7'd60);
        checks++; if (s_raddr[1] !== 14'd2250) begin errors++; $display("FAIL clean_rd_b raddr=%0d required 2250", s_raddr[1]); end
        checks++; if (s_raddr[2] !== 14'd6770) begin errors++; $display("FAIL clean_rd_r raddr=%0d required 6770", s_raddr[2]); end
        checks++; if (s_we[4] !== 1'b1 || s_waddr[4] !== 14'd2250 || s_wdata[4] !== 3'd1) begin
            errors++; $display("FAIL clean_wr_b we=%b addr=%0d data=%0d required 1/2250/1", s_we[4], s_waddr[4], s_wdata[4]); end
        checks++; if (s_we[5] !== 1'b1 || s_waddr[5] !== 14'd6770 || s_wdata[5] !== 3'd2) begin
            errors++; $display("FAIL clean_wr_r we=%b addr=%0d data=%0d required 1/6770/2", s_we[5], s_waddr[5], s_wdata[5]); end
        checks++; if (s_we[3] !== 1'b0 || s_we[6] !== 1'b0) begin
            errors++; $display("FAIL clean_we_window we3=%b we6=%b required 0 0", s_we[3], s_we[6]); end
        checks++; if (s_done[5] !== 1'b0 || s_done[6] !== 1'b1 || s_done[7] !== 1'b0) begin
            errors++; $display("FAIL clean_done d5=%b d6=%b d7=%b required 0 1 0", s_done[5], s_done[6], s_done[7]); end
        checks++; if (s_busy[6] !== 1'b1 || s_busy[7] !== 1'b0) begin
            errors++; $display("FAIL clean_busy b6=%b b7=%b required 1 0", s_busy[6], s_busy[7]); end
        checks++; if (s_cb[6] !== 1'b0 || s_cr[6] !== 1'b0) begin
            errors++; $display("FAIL clean_flags got=%b%b required 00", s_cb[6], s_cr[6]); end
        miss = 0;
        for (int t = 1; t <= 7; t++) if (s_miss[t] === 1'b1) miss++;
        checks++; if (miss != 0) begin errors++; $display("FAIL clean_missed pulses=%0d required 0", miss); end
        checks++; if (ram[2250] !== 3'd1 || ram[6770] !== 3'd2) begin
            errors++; $display("FAIL clean_ram c2250=%0d c6770=%0d required 1 2", ram[2250], ram[6770]); end
    endtask

    task automatic test_trail_hit;
        @(negedge Clk);
        poke_addr = 14'd2250; poke_val = 3'd2; poke_req = 1'b1;
        @(negedge Clk);
        poke_req = 1'b0;
        run_frame(7'd10, 7'd20, 7'd50, 7'd61);
        checks++; if (s_cb[3] !== 1'b0 || s_cb[4] !== 1'b1) begin
            errors++; $display("FAIL hit_blue_flag chk=%b wr_b=%b required 0 1", s_cb[3], s_cb[4]); end
        checks++; if (s_we[4] !== 1'b0) begin errors++; $display("FAIL hit_blue_nowrite we=%b required 0", s_we[4]); end
        checks++; if (s_we[5] !== 1'b1 || s_waddr[5] !== 14'd6882 || s_wdata[5] !== 3'd2) begin
            errors++; $display("FAIL hit_red_write we=%b addr=%0d data=%0d required 1/6882/2", s_we[5], s_waddr[5], s_wdata[5]); end
        checks++; if (s_cr[6] !== 1'b0) begin errors++; $display("FAIL hit_red_flag got=%b required 0", s_cr[6]); end
    endtask

    task automatic test_bounds;
        run_frame(7'd11, 7'd20, 7'd112, 7'd0);
        checks++; if (s_raddr[1] !== 14'd2251) begin errors++; $display("FAIL oob_rd_b raddr=%0d required 2251", s_raddr[1]); end
        checks++; if (s_raddr[2] !== 14'd0) begin errors++; $display("FAIL oob_rd_r raddr=%0d required 0", s_raddr[2]); end
        checks++; if (s_cr[4] !== 1'b1) begin errors++; $display("FAIL oob_red_flag got=%b required 1", s_cr[4]); end
        checks++; if (s_cb[4] !== 1'b1) begin errors++; $display("FAIL oob_blue_hold got=%b required 1", s_cb[4]); end
        checks++; if (s_we[4] !== 1'b0 || s_we[5] !== 1'b0) begin
            errors++; $display("FAIL oob_nowrite we4=%b we5=%b required 0 0", s_we[4], s_we[5]); end
    endtask

    task automatic test_headon;
        run_frame(7'd5, 7'd5, 7'd5, 7'd5);
`ifdef TRAIL_HEADON_EN
        checks++; if (s_cb[4] !== 1'b1 || s_cr[4] !== 1'b1) begin
            errors++; $display("FAIL headon_flags got=%b%b required 11", s_cb[4], s_cr[4]); end
        checks++; if (s_we[4] !== 1'b0 || s_we[5] !== 1'b0) begin
            errors++; $display("FAIL headon_nowrite we4=%b we5=%b required 0 0", s_we[4], s_we[5]); end
`else
        checks++; if (s_cb[4] !== 1'b0 || s_cr[4] !== 1'b0) begin
            errors++; $display("FAIL headon_flags got=%b%b required 00", s_cb[4], s_cr[4]); end
        checks++; if (s_we[4] !== 1'b1 || s_waddr[4] !== 14'd565 || s_wdata[4] !== 3'd1) begin
            errors++; $display("FAIL headon_wr_b we=%b addr=%0d data=%0d required 1/565/1", s_we[4], s_waddr[4], s_wdata[4]); end
        checks++; if (s_we[5] !== 1'b1 || s_waddr[5] !== 14'd565 || s_wdata[5] !== 3'd2) begin
            errors++; $display("FAIL headon_wr_r we=%b addr=%0d data=%0d required 1/565/2", s_we[5], s_waddr[5], s_wdata[5]); end
`endif
    endtask

    task automatic test_reset_mid_frame;
        logic found;
        Blue_X = 7'd1; Blue_Y = 7'd1; Red_X = 7'd112; Red_Y = 7'd0;
        @(negedge Clk);
        frame_clk = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge Clk);
            if (busy === 1'b1) found = 1'b1;
        end
        repeat (3) @(negedge Clk);
        checks++; if (found !== 1'b1 || busy !== 1'b1 || collision_red !== 1'b1) begin
            errors++; $display("FAIL midrst_pre busy=%b red=%b required 1 1", busy, collision_red); end
        Reset = 1'b1; frame_clk = 1'b0;
        @(negedge Clk);
        checks++; if ({mem_we, busy, frame_done, frame_missed, collision_blue, collision_red} !== 6'b0) begin
            errors++; $display("FAIL midrst_outputs got=%b required 000000",
                {mem_we, busy, frame_done, frame_missed, collision_blue, collision_red}); end
        checks++; if (mem_waddr !== 14'd0 || mem_raddr !== 14'd0 || mem_wdata !== 3'd0) begin
            errors++; $display("FAIL midrst_addr waddr=%0d raddr=%0d wdata=%0d required 0", mem_waddr, mem_raddr, mem_wdata); end
        Reset = 1'b0;
        repeat (8) @(negedge Clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle busy=%b required 0", busy); end
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; Game_State = 3'd0;
        Blue_X = '0; Blue_Y = '0; Red_X = '0; Red_Y = '0;
        Blue_dir = '0; Red_dir = '0;
        fill_req = 1'b0; poke_req = 1'b0; fill_val = '0; poke_val = '0; poke_addr = '0;
        test_reset();
        test_clear(1'b0);
        test_clean_frame();
        test_trail_hit();
        test_bounds();
        test_clear(1'b1);
        test_headon();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
